// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern transmitter and its run monitor.
package pattern_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ONES  = 3'b010,
    ST_ZEROS = 3'b100
  } state_t;

  localparam int LEN_W_DEF  = 4;
  localparam int THRESH_DEF = 4;

endpackage

// File: rtl/pattern_tx_run_monitor.sv
// Tracks consecutive ones on w and predicts the detector output one cycle later.
module run_monitor
  import pattern_tx_pkg::*;
#(
  parameter int THRESH = THRESH_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic w,
  output logic exp_z
);

  localparam int CNT_W = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] INC = CNT_W'(1);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_next;

  // Saturating run length, cleared by any zero on w.
  always_comb begin
    run_next = '0;
    if (!w) begin
      run_next = '0;
    end else if (run_cnt == SAT) begin
      run_next = SAT;
    end else begin
      run_next = run_cnt + INC;
    end
  end

  // Run counter and registered expectation.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
      exp_z   <= 1'b0;
    end else begin
      run_cnt <= run_next;
      exp_z   <= (run_next == SAT);
    end
  end

endmodule

// File: rtl/pattern_tx.sv
// Serializes (ones, zeros) run commands onto w and predicts the detector's z.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_ones,
  input  logic [LEN_W-1:0] cmd_zeros,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic             exp_z
);

  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO = '0;

  state_t           state;
  logic [LEN_W-1:0] ones_left;
  logic [LEN_W-1:0] zeros_left;
  logic             noop_done;
  logic             last_bit;
  logic             accept;

  // Counters hold the bits still to show, including the one currently on w.
  always_comb begin
    last_bit = 1'b0;
    case (state)
      ST_ONES:  last_bit = (ones_left == ONE) && (zeros_left == ZERO);
      ST_ZEROS: last_bit = (zeros_left == ONE);
      default:  last_bit = 1'b0;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE) || last_bit;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = last_bit || noop_done;

  // Command sequencer: loads on accept, otherwise walks the ones then zeros.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ones_left  <= ZERO;
      zeros_left <= ZERO;
      w          <= 1'b0;
      noop_done  <= 1'b0;
    end else if (accept) begin
      ones_left  <= cmd_ones;
      zeros_left <= cmd_zeros;
      noop_done  <= (cmd_ones == ZERO) && (cmd_zeros == ZERO);
      if (cmd_ones != ZERO) begin
        state <= ST_ONES;
        w     <= 1'b1;
      end else if (cmd_zeros != ZERO) begin
        state <= ST_ZEROS;
        w     <= 1'b0;
      end else begin
        state <= ST_IDLE;
        w     <= 1'b0;
      end
    end else begin
      noop_done <= 1'b0;
      case (state)
        ST_ONES: begin
          if (ones_left == ONE) begin
            ones_left <= ZERO;
            w         <= 1'b0;
            if (zeros_left != ZERO) begin
              state <= ST_ZEROS;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            ones_left <= ones_left - ONE;
            w         <= 1'b1;
          end
        end
        ST_ZEROS: begin
          w <= 1'b0;
          if (zeros_left == ONE) begin
            zeros_left <= ZERO;
            state      <= ST_IDLE;
          end else begin
            zeros_left <= zeros_left - ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          w     <= 1'b0;
        end
      endcase
    end
  end

  run_monitor #(.THRESH(THRESH)) u_run_monitor (
    .clock (clock),
    .rst   (rst),
    .w     (w),
    .exp_z (exp_z)
  );

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized scoreboard bench for pattern_tx with a per-cycle expected bit stream.
module tb_pattern_tx;

  localparam int LEN_W  = 4;
  localparam int THRESH = 4;

  logic             clock = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_ones = '0;
  logic [LEN_W-1:0] cmd_zeros = '0;
  logic             cmd_ready;
  logic             w;
  logic             busy;
  logic             done;
  logic             exp_z;

  typedef struct packed {
    logic w;
    logic busy;
    logic done;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    run_len = 0;

  pattern_tx #(.LEN_W(LEN_W), .THRESH(THRESH)) dut (
    .clock     (clock),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ones  (cmd_ones),
    .cmd_zeros (cmd_zeros),
    .w         (w),
    .busy      (busy),
    .done      (done),
    .exp_z     (exp_z)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected beat per cycle; an empty queue means the idle pattern.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clock);
      if (!rst) begin
        exp_q.delete();
        run_len = 0;
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        chk("w", w, e.w);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("cmd_ready", cmd_ready, !e.busy || e.done);
        chk("exp_z", exp_z, run_len >= THRESH);
        run_len = e.w ? ((run_len < THRESH) ? run_len + 1 : THRESH) : 0;
      end
    end
  end

  // Entered and left at posedge+1. Holds valid with junk fields while not ready.
  task automatic send(input int ones, input int zeros, input int gap);
    int budget = 0;
    cmd_valid = 1'b1;
    cmd_ones  = LEN_W'($urandom);
    cmd_zeros = LEN_W'($urandom);
    while (!cmd_ready && budget < 40) begin
      @(posedge clock); #1;
      cmd_ones  = LEN_W'($urandom);
      cmd_zeros = LEN_W'($urandom);
      budget++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    cmd_ones  = LEN_W'(ones);
    cmd_zeros = LEN_W'(zeros);
    @(posedge clock); #1;
    if (ones == 0 && zeros == 0) begin
      exp_q.push_back('{w: 1'b0, busy: 1'b0, done: 1'b1});
    end else begin
      for (int i = 0; i < ones; i++)
        exp_q.push_back('{w: 1'b1, busy: 1'b1, done: (i == ones - 1) && (zeros == 0)});
      for (int i = 0; i < zeros; i++)
        exp_q.push_back('{w: 1'b0, busy: 1'b1, done: (i == zeros - 1)});
    end
    cmd_valid = 1'b0;
    cmd_ones  = LEN_W'($urandom);
    cmd_zeros = LEN_W'($urandom);
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int ones;
    int zeros;
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("reset_w", w, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_exp_z", exp_z, 1'b0);
    chk("reset_ready", cmd_ready, 1'b1);
    rst = 1'b1;
    @(posedge clock); #1;

    send(4, 2, 8);
    send(6, 1, 8);
    send(3, 0, 0);
    send(2, 1, 8);
    send(3, 3, 8);
    send(0, 0, 3);
    send(0, 0, 0);
    send(15, 15, 2);

    // Asynchronous reset during the sixth one of an eight-long run.
    send(8, 0, 0);
    repeat (5) @(posedge clock);
    #2;
    chk("pre_reset_w", w, 1'b1);
    chk("pre_reset_exp_z", exp_z, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_w", w, 1'b0);
    chk("async_reset_exp_z", exp_z, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    repeat (2) @(posedge clock);
    #2 rst = 1'b1;
    @(posedge clock); #1;
    send(4, 1, 4);

    for (int k = 0; k < 40; k++) begin
      ones  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      zeros = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      send(ones, zeros, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
